tt_um_murra232_uart_tx: RTL and testbench

- Serial transmitter: the sending end for the team's single-bit sampled-input designs. It produces a framed serial bit stream that a downstream flip-flop or receiver samples on ui_in[0].
- Accepts one 8-bit parallel byte per handshake and shifts it out as a UART-style frame: 1 start bit, 8 data bits LSB-first, 1 stop bit.
- Sits as a Tiny Tapeout user top-level using the standard tt_um port set.

---
 rtl/tt_um_murra232_uart_tx.sv | 113 +++++++++++
 tb/tb_tt_um_murra232_uart_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_murra232_uart_tx.sv
// UART-style serial transmitter: 1 start bit, 8 data bits LSB-first, 1 stop bit.
// One byte is accepted per handshake on uio_in[0] while idle; status is reported on uo_out.
module tt_um_murra232_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

    state_t     state_q;
    logic [7:0] shift_q;
    logic [7:0] baud_q;
    logic [2:0] bit_q;
    logic       tx_q;
    logic       done_q;

    logic tx_valid;
    logic baud_term;
    logic ready;
    logic busy;

    assign tx_valid  = uio_in[0];
    assign baud_term = (baud_q == BAUD_LAST);
    assign ready     = (state_q == IDLE);
    assign busy      = ~ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= 8'h00;
            baud_q  <= 8'h00;
            bit_q   <= 3'd0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    baud_q <= 8'h00;
                    if (tx_valid) begin
                        shift_q <= ui_in;
                        state_q <= START;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_term) begin
                        baud_q  <= 8'h00;
                        bit_q   <= 3'd0;
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 8'd1;
                    end
                end
                DATA: begin
                    if (baud_term) begin
                        baud_q  <= 8'h00;
                        shift_q <= {1'b0, shift_q[7:1]};
                        // tx is registered, so it loads the bit that becomes shift_q[0] next
                        if (bit_q == 3'd7) begin
                            bit_q   <= 3'd0;
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 8'd1;
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (baud_term) begin
                        baud_q  <= 8'h00;
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign uo_out  = {4'b0000, done_q, ready, busy, tx_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    wire unused = &{1'b0, ena, uio_in[7:1]};

endmodule

// File: tb/tb_tt_um_murra232_uart_tx.sv
// Directed plus randomized bench for the UART transmitter, with a frame-level
// reference model and a mid-bit sampling receiver on the serial line.
module tb_tt_um_murra232_uart_tx;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad = 0;

    logic [8:0] rx_q[$];
    logic [7:0] rx_d;
    logic       rx_err;

    tt_um_murra232_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial level expected idx cycles after the first low cycle of a frame carrying b.
    function automatic logic exp_tx(input logic [7:0] b, input int idx);
        int slot;
        slot = idx / N;
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return b[slot-1];
    endfunction

    // Receiver: detects the start edge and samples each bit in its middle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && uo_out[0] === 1'b0) begin
                rx_err = 1'b0;
                repeat (N / 2) @(posedge clk);
                #1;
                if (uo_out[0] !== 1'b0) rx_err = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    repeat (N) @(posedge clk);
                    #1;
                    rx_d[k] = uo_out[0];
                end
                repeat (N) @(posedge clk);
                #1;
                if (uo_out[0] !== 1'b1) rx_err = 1'b1;
                rx_q.push_back({rx_err, rx_d});
            end
        end
    end

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (uo_out[2] !== 1'b1 && n < 20 * N) begin
            tick();
            n++;
        end
        if (uo_out[2] !== 1'b1) chk({tag, "_ready_timeout"}, {31'd0, uo_out[2]}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_ready("send");
        ui_in = b;
        uio_in[0] = 1'b1;
        tick();
        uio_in[0] = 1'b0;
        ui_in = 8'($urandom);
    endtask

    // Sends b and checks every cycle of the frame against the model.
    task automatic send_frame_check(input logic [7:0] b, input string tag);
        wait_ready(tag);
        ui_in = b;
        uio_in[0] = 1'b1;
        tick();
        uio_in[0] = 1'b0;
        ui_in = 8'($urandom);
        for (int i = 0; i < 10 * N; i++) begin
            chk({tag, "_tx"}, {31'd0, uo_out[0]}, {31'd0, exp_tx(b, i)});
            chk({tag, "_busy"}, {31'd0, uo_out[1]}, 32'd1);
            tick();
        end
        chk({tag, "_done_cycle"}, {24'd0, uo_out}, 32'h0D);
        tick();
        chk({tag, "_after_done"}, {24'd0, uo_out}, 32'h05);
    endtask

    task automatic rx_expect(input logic [7:0] b, input string tag);
        if (rx_q.size() == 0) begin
            chk({tag, "_rx_empty"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_rx"}, {23'd0, rx_q.pop_front()}, {24'd0, b});
        end
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] b2b[2];

        // reset held with tx_valid asserted
        uio_in[0] = 1'b1;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reset_uo_out", {24'd0, uo_out}, 32'h05);
        end
        chk("reset_uio_out", {24'd0, uio_out}, 32'h00);
        chk("reset_uio_oe", {24'd0, uio_oe}, 32'h00);
        uio_in[0] = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", {24'd0, uo_out}, 32'h05);
        repeat (3) tick();

        // single frame
        rx_q.delete();
        send_frame_check(8'hA5, "frame_a5");
        repeat (3) tick();
        rx_expect(8'hA5, "frame_a5");

        // data stability and valid ignored while busy
        rx_q.delete();
        ui_in = 8'h3C;
        uio_in[0] = 1'b1;
        tick();
        uio_in[0] = 1'b0;
        for (int i = 0; i < 10 * N; i++) begin
            if (i == 15) begin
                ui_in = 8'hFF;
                uio_in[0] = 1'b1;
            end
            if (i == 16) uio_in[0] = 1'b0;
            chk("stable_tx", {31'd0, uo_out[0]}, {31'd0, exp_tx(8'h3C, i)});
            tick();
        end
        chk("stable_done", {24'd0, uo_out}, 32'h0D);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stable_no_second", {24'd0, uo_out}, 32'h05);
        end
        rx_expect(8'h3C, "stable");
        chk("stable_rx_count", rx_q.size(), 32'd0);

        // back-to-back with valid held high
        rx_q.delete();
        b2b[0] = 8'h00;
        b2b[1] = 8'hFF;
        ui_in = b2b[0];
        uio_in[0] = 1'b1;
        tick();
        ui_in = b2b[1];
        for (int i = 0; i <= 20 * N; i++) begin
            logic e;
            if (i < 10 * N) e = exp_tx(b2b[0], i);
            else if (i == 10 * N) e = 1'b1;
            else e = exp_tx(b2b[1], i - 10 * N - 1);
            chk("b2b_tx", {31'd0, uo_out[0]}, {31'd0, e});
            chk("b2b_busy", {31'd0, uo_out[1]}, (i == 10 * N) ? 32'd0 : 32'd1);
            if (i == 10 * N + 1) uio_in[0] = 1'b0;
            tick();
        end
        chk("b2b_done", {24'd0, uo_out}, 32'h0D);
        repeat (3) tick();
        rx_expect(8'h00, "b2b_first");
        rx_expect(8'hFF, "b2b_second");

        // reset mid-frame during data bit 3 of 0x55
        ui_in = 8'h55;
        uio_in[0] = 1'b1;
        tick();
        uio_in[0] = 1'b0;
        repeat (18) tick();
        chk("midrst_before", {31'd0, uo_out[0]}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_async", {24'd0, uo_out}, 32'h05);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_held", {24'd0, uo_out}, 32'h05);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12 * N; i++) begin
            tick();
            chk("midrst_quiet", {28'd0, uo_out[3:0]}, 32'h05);
        end
        rx_q.delete();
        send_frame_check(8'h81, "after_rst");
        repeat (3) tick();
        rx_expect(8'h81, "after_rst");

        // randomized frames
        for (int r = 0; r < 6; r++) begin
            rx_q.delete();
            rb = 8'($urandom);
            send_frame_check(rb, "rand");
            repeat (2) tick();
            rx_expect(rb, "rand");
        end

        // loopback of every byte value
        rx_q.delete();
        for (int v = 0; v < 256; v++) send_byte(8'(v));
        wait_ready("loop_end");
        repeat (4) tick();
        chk("loop_count", rx_q.size(), 32'd256);
        for (int v = 0; v < 256; v++) rx_expect(8'(v), "loop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
